// File: rtl/relu_maxpool_writer.sv
`default_nettype none
// ============================================================================
// Module      : relu_maxpool_writer
// Description : ReLU + 2x2/stride-2 max pooling of a row-major float32 map.
//               The pooled map is written to consecutive addresses from a base.
//               Optional macro POOL_RELU_EN: ReLU with unsigned max; otherwise
//               no ReLU and max is a full sign-magnitude float compare.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool_writer #(
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_PICT_WIDTH = 9,
   parameter int MAX_ADDR_WIDTH = 32,
   parameter int LINE_DEPTH     = 256
) (
   input  logic                      Clk0,
   input  logic                      Rst,
   input  logic                      start_in,
   input  logic [MAX_PICT_WIDTH-1:0] pict_size_in,
   input  logic [MAX_ADDR_WIDTH-1:0] out_addr_in,
   input  logic                      result_valid_in,
   input  logic [DATA_WIDTH-1:0]     result_data_in,
   output logic                      mem_wen_out,
   output logic [MAX_ADDR_WIDTH-1:0] mem_waddr_out,
   output logic [DATA_WIDTH-1:0]     mem_wdata_out,
   output logic                      busy_out,
   output logic                      done_out
);

   localparam int          LB_AW      = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
   localparam logic [31:0] LB_DEPTH_U = LINE_DEPTH;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]                state;
   logic [MAX_PICT_WIDTH-1:0] n_reg;
   logic [MAX_ADDR_WIDTH-1:0] base;
   logic [MAX_PICT_WIDTH-1:0] row;
   logic [MAX_PICT_WIDTH-1:0] col;
   logic [MAX_ADDR_WIDTH-1:0] k;
   logic [DATA_WIDTH-1:0]     hold;
   logic [DATA_WIDTH-1:0]     linebuf [LINE_DEPTH];

   logic [MAX_PICT_WIDTH-1:0] last;
   logic [MAX_PICT_WIDTH-1:0] col_half;
   logic [LB_AW-1:0]          lb_idx;
   logic                      lb_ok;
   logic [DATA_WIDTH-1:0]     lb_rd;
   logic [DATA_WIDTH-1:0]     x;
   logic                      accept;

   // Ties always return the first operand a.
   function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
`ifdef POOL_RELU_EN
      return (b > a) ? b : a;
`else
      if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
         return a[DATA_WIDTH-1] ? b : a;
      else if (!a[DATA_WIDTH-1])
         return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
      else
         return (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) ? b : a;
`endif
   endfunction

`ifdef POOL_RELU_EN
   assign x = result_data_in[DATA_WIDTH-1] ? '0 : result_data_in;
`else
   assign x = result_data_in;
`endif

   assign last     = n_reg - MAX_PICT_WIDTH'(1);
   assign col_half = col >> 1;
   assign lb_idx   = LB_AW'(col_half);
   assign lb_ok    = (32'(col_half) < LB_DEPTH_U);
   assign lb_rd    = lb_ok ? linebuf[lb_idx] : '0;
   assign accept   = (state == RUN) && result_valid_in;

   // Pooled columns beyond the line buffer are dropped, never aliased.
   always_ff @(posedge Clk0) begin
      if (!Rst && accept && !row[0] && col[0] && lb_ok)
         linebuf[lb_idx] <= fmax(hold, x);
   end

   always_ff @(posedge Clk0) begin
      if (Rst) begin
         state         <= IDLE;
         n_reg         <= '0;
         base          <= '0;
         row           <= '0;
         col           <= '0;
         k             <= '0;
         hold          <= '0;
         mem_wen_out   <= 1'b0;
         mem_waddr_out <= '0;
         mem_wdata_out <= '0;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
      end else begin
         mem_wen_out <= 1'b0;
         done_out    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  if (pict_size_in >= MAX_PICT_WIDTH'(2)) begin
                     n_reg    <= pict_size_in;
                     base     <= out_addr_in;
                     row      <= '0;
                     col      <= '0;
                     k        <= '0;
                     busy_out <= 1'b1;
                     state    <= RUN;
                  end else begin
                     // Degenerate map: nothing to pool, just acknowledge.
                     done_out <= 1'b1;
                     state    <= FINISH;
                  end
               end
            end
            RUN: begin
               if (result_valid_in) begin
                  case ({row[0], col[0]})
                     2'b00: hold <= x;
                     2'b10: hold <= fmax(lb_rd, x);
                     2'b11: begin
                        if (lb_ok) begin
                           mem_wen_out   <= 1'b1;
                           mem_waddr_out <= base + k;
                           mem_wdata_out <= fmax(hold, x);
                           k             <= k + MAX_ADDR_WIDTH'(1);
                        end
                     end
                     default: ;
                  endcase
                  if (col == last) begin
                     col <= '0;
                     row <= row + MAX_PICT_WIDTH'(1);
                     if (row == last) begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        state    <= FINISH;
                     end
                  end else begin
                     col <= col + MAX_PICT_WIDTH'(1);
                  end
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
